div_unit: RTL

Iterative restoring divider that answers the calculator top-level control unit's divide request. It sits in the datapath beside the small-calc and multiply units. It accepts a one-cycle Go pulse with unsigned dividend/divisor and returns quotient and remainder with a one-cycle Done pulse. A zero divisor produces a one-cycle Err pulse instead. It supplies the Done_DIV / Err inputs that the control unit's divide wait state polls.

---
 rtl/div_unit_if.sv | 33 +++
 rtl/div_unit.sv | 103 ++++++++++
 2 files changed

// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_if
// Description : Request/response bundle between the control unit and the
//               iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_unit_if #(
  parameter int WIDTH = 4
);
  logic             Go;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             Done;
  logic             Err;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             Busy;
  logic [1:0]       CS;

  // Requester side (control unit / testbench)
  modport master (
    output Go, X, Y,
    input  Done, Err, Q, R, Busy, CS
  );

  // Divider side
  modport slave (
    input  Go, X, Y,
    output Done, Err, Q, R, Busy, CS
  );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Iterative restoring divider, one quotient bit per cycle,
//               Moore Done/Err pulses for the control unit's divide wait.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
  parameter int WIDTH = 4
) (
  input  wire logic   clk,
  input  wire logic   rst,
  div_unit_if.slave   bus
);

  localparam int          CW     = $clog2(WIDTH + 1);
  localparam logic [1:0]  S_IDLE = 2'b00;
  localparam logic [1:0]  S_ITER = 2'b01;
  localparam logic [1:0]  S_DONE = 2'b10;
  localparam logic [1:0]  S_ERR  = 2'b11;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  // Remainder MSB is always zero after a restoring step, so only WIDTH bits
  // are stored; the WIDTH+1-bit arithmetic lives in the trial subtraction.
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};

  always_comb begin
    w_rem_nxt = w_shift[WIDTH-1:0];
    w_quo_nxt = {r_quo[WIDTH-2:0], 1'b0};
    if (!w_trial[WIDTH]) begin
      w_rem_nxt = w_trial[WIDTH-1:0];
      w_quo_nxt = {r_quo[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Go) begin
            r_quo   <= bus.X;
            r_dvs   <= bus.Y;
            r_rem   <= '0;
            r_cnt   <= CW'(WIDTH);
            r_state <= (bus.Y == '0) ? S_ERR : S_ITER;
          end
        end
        S_ITER: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - CW'(1);
          // Results land on the final edge so they are valid during Done.
          if (r_cnt == CW'(1)) begin
            r_q     <= w_quo_nxt;
            r_r     <= w_rem_nxt;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_q     <= '0;
          r_r     <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Done = (r_state == S_DONE);
  assign bus.Err  = (r_state == S_ERR);
  assign bus.Busy = (r_state != S_IDLE);
  assign bus.CS   = r_state;
  assign bus.Q    = r_q;
  assign bus.R    = r_r;

endmodule
`default_nettype wire
